// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and default width for bit_serial_adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t;
  localparam int SADD_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/adder.sv
// adder: 1-bit full-adder cell
module adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic S,
  output logic co
);
  assign S  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial add of two WIDTH-bit operands through one full-adder cell
// Define BIT_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module bit_serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SADD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout_out
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  sadd_state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0] cnt;
  logic carry, s, co;
  adder u_adder (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .S(s), .co(co));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sum_out   = sum_sh;
  assign cout_out  = carry;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_sh  <= a_in;
        b_sh  <= b_in;
        carry <= cin;
        cnt   <= CW'(WIDTH - 1);
        state <= RUN;
      end
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= WIDTH'({s, sum_sh} >> 1);
      carry  <= co;
      if (cnt == '0) state <= DONE;
      else cnt <= cnt - CW'(1);
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
`ifdef BIT_SERIAL_ADDER_OVF_EN
  // On the last RUN cycle carry is the carry into the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (state == RUN && cnt == '0) ovf <= carry ^ co;
  end
`endif
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: vector table, random ops vs arithmetic model, backpressure and reset sequences
module tb_bit_serial_adder;
  localparam int W = 8;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 0;
  logic in_ready, out_valid, cout_out, ovf_w;
  logic [W-1:0] a_in = '0, b_in = '0, sum_out;
  int n_chk = 0, n_fail = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out),
`ifdef BIT_SERIAL_ADDER_OVF_EN
    .ovf(ovf_w),
`endif
    .cout_out(cout_out)
  );
`ifndef BIT_SERIAL_ADDER_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] s;
    logic         co, v;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] s, output logic co, output logic v, output int lat);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s = sum_out; co = cout_out; v = ovf_w;
  endtask

  task automatic release_out;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  initial begin
    vec_t vt[6];
    logic [W-1:0] s, ra, rb;
    logic co, v, rc;
    logic [W:0] full;
    int lat;
    vt[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1};
    vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset sum_out", sum_out, 0);
    check("reset cout_out", cout_out, 0);
    @(negedge clk) rst = 0;

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].c, s, co, v, lat);
      check($sformatf("vec%0d latency", i), lat, W);
      check($sformatf("vec%0d sum", i), s, vt[i].s);
      check($sformatf("vec%0d cout", i), co, vt[i].co);
`ifdef BIT_SERIAL_ADDER_OVF_EN
      check($sformatf("vec%0d ovf", i), v, vt[i].v);
`endif
      release_out;
      check($sformatf("vec%0d back to idle", i), in_ready, 1);
    end

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      full = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
      run_op(ra, rb, rc, s, co, v, lat);
      check($sformatf("rnd%0d latency", i), lat, W);
      check($sformatf("rnd%0d sum", i), s, full[W-1:0]);
      check($sformatf("rnd%0d cout", i), co, full[W]);
`ifdef BIT_SERIAL_ADDER_OVF_EN
      check($sformatf("rnd%0d ovf", i), v, model_ovf(ra, rb, full[W-1:0]));
`endif
      release_out;
    end

    // backpressure: result held, new operands ignored
    run_op(8'h12, 8'h34, 1'b0, s, co, v, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1; a_in = 8'hFF; b_in = 8'hFF; cin = 1;
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp sum", sum_out, 8'h46);
      check("bp cout", cout_out, 0);
    end
    @(negedge clk) in_valid = 0;
    check("bp sum after pulses", sum_out, 8'h46);
    release_out;
    check("bp idle out_valid", out_valid, 0);
    check("bp idle in_ready", in_ready, 1);

    // reset after 3 RUN cycles
    @(negedge clk);
    a_in = 8'hAB; b_in = 8'hCD; cin = 1; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    check("rst-run out_valid", out_valid, 0);
    check("rst-run sum", sum_out, 0);
    check("rst-run cout", cout_out, 0);
    check("rst-run in_ready", in_ready, 1);
    @(negedge clk) rst = 0;
    run_op(8'h01, 8'h01, 1'b0, s, co, v, lat);
    check("post-rst latency", lat, W);
    check("post-rst sum", s, 8'h02);
    check("post-rst cout", co, 0);
    release_out;

    // reset while holding a result in DONE
    run_op(8'hF0, 8'h0F, 1'b1, s, co, v, lat);
    check("pre-rst-done sum", s, 8'h00);
    check("pre-rst-done cout", co, 1);
    #1 rst = 1;
    #1;
    check("rst-done out_valid", out_valid, 0);
    check("rst-done sum", sum_out, 0);
    check("rst-done cout", cout_out, 0);
    check("rst-done ovf", ovf_w, 0);
    @(negedge clk) rst = 0;
    @(negedge clk);
    check("rst-done in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
